// File: rtl/lsp_prev_update_if.sv
// ---------------------------------------------------------------------------
// lsp_prev_update_if : start/adder/scratch-memory bundle of lsp_prev_update
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface lsp_prev_update_if;
  logic        start;
  logic [11:0] lspEleAddr;
  logic [15:0] addIn;
  logic [31:0] memIn;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic [11:0] memReadAddr;
  logic [11:0] memWriteAddr;
  logic [31:0] memOut;
  logic        memWriteEn;
  logic        done;

  modport slave (
    input  start, lspEleAddr, addIn, memIn,
    output add_a, add_b, memReadAddr, memWriteAddr, memOut, memWriteEn, done
  );

  modport master (
    output start, lspEleAddr, addIn, memIn,
    input  add_a, add_b, memReadAddr, memWriteAddr, memOut, memWriteEn, done
  );
endinterface

`default_nettype wire

// File: rtl/lsp_prev_update.sv
// ---------------------------------------------------------------------------
// lsp_prev_update : shifts the freq_prev history down one row, loads lsp_ele
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsp_prev_update #(
  parameter logic [15:0] M         = 16'd10,
  parameter logic [15:0] MA_NP     = 16'd4,
  parameter logic [11:0] FREQ_PREV = 12'h100
) (
  input  wire logic         clk,
  input  wire logic         reset,
  lsp_prev_update_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_NXT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] k_q, k_d;
  logic [15:0] j_q, j_d;
  logic        done_q, done_d;

  logic [11:0] rd_addr;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_en;
  logic [15:0] op_a;
  logic [15:0] op_b;

  logic [1:0]  src_row;
  logic [11:0] src_addr;
  logic [11:0] dst_addr;
  logic        unused_ele_lsbs;

  // Row k is filled from row k-1; row 0 is filled from the lsp_ele vector.
  assign src_row  = k_q[1:0] - 2'd1;
  assign src_addr = (k_q == 16'd0) ? {bus.lspEleAddr[11:4], j_q[3:0]}
                                   : {FREQ_PREV[11:6], src_row, j_q[3:0]};
  assign dst_addr = {FREQ_PREV[11:6], k_q[1:0], j_q[3:0]};

  assign unused_ele_lsbs = ^bus.lspEleAddr[3:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= 16'd0;
      j_q     <= 16'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      j_q     <= j_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    j_d     = j_q;
    done_d  = 1'b0;
    rd_addr = 12'd0;
    wr_addr = 12'd0;
    wr_data = 32'd0;
    wr_en   = 1'b0;
    op_a    = 16'd0;
    op_b    = 16'd0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          k_d     = MA_NP - 16'd1;
          j_d     = 16'd0;
          state_d = S_RD;
        end
      end

      S_RD: begin
        rd_addr = src_addr;
        state_d = S_WR;
      end

      S_WR: begin
        rd_addr = src_addr;
        wr_addr = dst_addr;
        wr_data = bus.memIn;
        wr_en   = 1'b1;
        op_a    = j_q;
        op_b    = 16'd1;
        j_d     = bus.addIn;
        state_d = (bus.addIn == M) ? S_NXT : S_RD;
      end

      S_NXT: begin
        j_d = 16'd0;
        if (k_q == 16'd0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          op_a    = k_q;
          op_b    = 16'hFFFF;
          k_d     = bus.addIn;
          state_d = S_RD;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.memReadAddr  = rd_addr;
  assign bus.memWriteAddr = wr_addr;
  assign bus.memOut       = wr_data;
  assign bus.memWriteEn   = wr_en;
  assign bus.add_a        = op_a;
  assign bus.add_b        = op_b;
  assign bus.done         = done_q;

endmodule

`default_nettype wire

// File: tb/tb_lsp_prev_update.sv
// ---------------------------------------------------------------------------
// tb_lsp_prev_update : directed bench for lsp_prev_update
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lsp_prev_update;

  localparam logic [11:0] C_FREQ_PREV = 12'h100;
  localparam logic [11:0] C_LSP_ELE   = 12'h200;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lsp_prev_update_if bus ();

  lsp_prev_update #(
    .M         (16'd10),
    .MA_NP     (16'd4),
    .FREQ_PREV (C_FREQ_PREV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // External adder and 1-cycle scratch RAM with a bench preload port
  logic [31:0] mem [4096];
  logic        pl_we = 1'b0;
  logic [11:0] pl_addr = 12'd0;
  logic [31:0] pl_data = 32'd0;

  assign bus.addIn = bus.add_a + bus.add_b;

  always @(posedge clk) begin
    bus.memIn <= mem[bus.memReadAddr];
    if (pl_we)
      mem[pl_addr] <= pl_data;
    else if (bus.memWriteEn)
      mem[bus.memWriteAddr] <= bus.memOut;
  end

  // Write monitor
  int          wr_total = 0;
  int          bad_j_cnt = 0;
  int          ov_cnt = 0;
  logic [11:0] log_addr [512];
  logic [31:0] log_data [512];

  always @(posedge clk) begin
    if (bus.memWriteEn) begin
      log_addr[wr_total % 512] <= bus.memWriteAddr;
      log_data[wr_total % 512] <= bus.memOut;
      wr_total <= wr_total + 1;
      if (bus.memWriteAddr[3:0] >= 4'd10)
        bad_j_cnt <= bad_j_cnt + 1;
    end
    if (bus.memWriteEn && bus.done)
      ov_cnt <= ov_cnt + 1;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [31:0] exp_rows [4][16];
  logic [31:0] ele_v [16];

  function automatic logic [31:0] pat(input int r, input int j);
    logic [3:0] rr;
    logic [3:0] jj;
    rr = r[3:0];
    jj = j[3:0];
    return {16'h0000, rr, 4'h0, jj, 4'h0};
  endfunction

  function automatic logic [11:0] row_addr(input int r, input int j);
    logic [1:0] rr;
    logic [3:0] jj;
    rr = r[1:0];
    jj = j[3:0];
    return {C_FREQ_PREV[11:6], rr, jj};
  endfunction

  task automatic load_word(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_we   = 1'b1;
    pl_addr = a;
    pl_data = d;
  endtask

  task automatic load_state();
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 16; j++)
        load_word(row_addr(r, j), exp_rows[r][j]);
    for (int j = 0; j < 16; j++)
      load_word(C_LSP_ELE | 12'(j), ele_v[j]);
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic apply_model();
    for (int r = 3; r >= 1; r--)
      for (int j = 0; j < 10; j++)
        exp_rows[r][j] = exp_rows[r-1][j];
    for (int j = 0; j < 10; j++)
      exp_rows[0][j] = ele_v[j];
  endtask

  task automatic verify(input string tag);
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 16; j++)
        chk($sformatf("%s_r%0dj%0d", tag, r, j), mem[row_addr(r, j)], exp_rows[r][j]);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rd_addr"}, 32'(bus.memReadAddr), 32'd0);
    chk({tag, "_wr_addr"}, 32'(bus.memWriteAddr), 32'd0);
    chk({tag, "_wr_data"}, bus.memOut, 32'd0);
    chk({tag, "_wr_en"}, 32'(bus.memWriteEn), 32'd0);
    chk({tag, "_add_a"}, 32'(bus.add_a), 32'd0);
    chk({tag, "_add_b"}, 32'(bus.add_b), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
  endtask

  // Single update with start pulsed for one cycle; checks latency and traffic
  task automatic run_once(input string tag, output int base);
    int cyc;
    bit seen;
    base = wr_total;
    @(negedge clk);
    bus.start = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
      bus.start = 1'b0;
      if (bus.done) seen = 1'b1;
    end
    chk({tag, "_done_cycle"}, 32'(cyc), 32'd85);
    chk({tag, "_writes"}, 32'(wr_total - base), 32'd40);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse_end"}, 32'(bus.done), 32'd0);
  endtask

  localparam int FPR [10] = '{2339, 4679, 7018, 9358, 11698, 14037, 16377, 18717, 21056, 23396};

  initial begin
    int base;
    int cyc;
    bit seen;

    bus.start      = 1'b0;
    bus.lspEleAddr = C_LSP_ELE;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_idle_outputs("idle");

    // Shift and load with patterned rows
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 16; j++)
        exp_rows[r][j] = pat(r, j);
    for (int j = 0; j < 16; j++)
      ele_v[j] = pat(15, j);
    load_state();
    run_once("shift", base);
    chk("first_wr_addr", 32'(log_addr[base % 512]), 32'h130);
    chk("first_wr_data", log_data[base % 512], 32'h0000_2000);
    chk("last_wr_addr", 32'(log_addr[(base + 39) % 512]), 32'h109);
    chk("last_wr_data", log_data[(base + 39) % 512], 32'h0000_F090);
    apply_model();
    verify("shift");

    // Chain: history freshly reset, lsp_ele = 1..10
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 10; j++)
        exp_rows[r][j] = 32'(FPR[j]);
    for (int j = 0; j < 16; j++)
      ele_v[j] = 32'(j + 1);
    load_state();
    run_once("chain", base);
    apply_model();
    verify("chain");

    // Mid-operation reset at cycle 30 (row 3 done, row 2 elements 0..3 written)
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 16; j++)
        exp_rows[r][j] = pat(r, j);
    for (int j = 0; j < 16; j++)
      ele_v[j] = pat(14, j);
    load_state();
    base = wr_total;
    @(negedge clk);
    bus.start = 1'b1;
    cyc = 0;
    while (cyc < 30) begin
      @(posedge clk);
      #1;
      cyc++;
      bus.start = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_idle_outputs("midrst");
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_writes", 32'(wr_total - base), 32'd14);
    for (int j = 0; j < 10; j++)
      exp_rows[3][j] = pat(2, j);
    for (int j = 0; j < 4; j++)
      exp_rows[2][j] = pat(1, j);
    verify("midrst_partial");
    run_once("after_rst", base);
    apply_model();
    verify("after_rst");

    // start held high across done, with stray pulses while busy
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 16; j++)
        exp_rows[r][j] = pat(r, j);
    for (int j = 0; j < 16; j++)
      ele_v[j] = pat(13, j);
    load_state();
    base = wr_total;
    @(negedge clk);
    bus.start = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.done) seen = 1'b1;
    end
    chk("held_done1_cycle", 32'(cyc), 32'd85);
    @(posedge clk);
    #1;
    cyc++;
    bus.start = 1'b0;
    chk("held_done1_pulse_end", 32'(bus.done), 32'd0);
    chk("held_restart_rd", 32'(bus.memReadAddr), 32'h120);
    seen = 1'b0;
    while (!seen && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      bus.start = (cyc == 100 || cyc == 150 || cyc == 151);
      if (bus.done) seen = 1'b1;
    end
    chk("held_done2_cycle", 32'(cyc), 32'd170);
    chk("held_writes", 32'(wr_total - base), 32'd80);
    @(posedge clk);
    #1;
    chk_idle_outputs("held_end");
    apply_model();
    apply_model();
    verify("held");

    chk("no_j_ge_10", 32'(bad_j_cnt), 32'd0);
    chk("we_done_overlap", 32'(ov_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
